// File: rtl/cu_pkg.sv
// ============================================================================
// Module   : cu_pkg
// Purpose  : Shared types and encodings for the CPU control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

  typedef enum logic [3:0] {
    ST_BOOT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_WB_ALU = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_IMM = 4'd7,
    ST_BRANCH = 4'd8,
    ST_CALL   = 4'd9,
    ST_HALT   = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU_RR = 2'b00,
    CLS_ALU_RI = 2'b01,
    CLS_MEM    = 2'b10,
    CLS_CTRL   = 2'b11
  } op_class_e;

  typedef enum logic [2:0] {
    SUB_LD  = 3'b000,
    SUB_ST  = 3'b001,
    SUB_LDI = 3'b010,
    SUB_LDA = 3'b011,
    SUB_STA = 3'b100
  } mem_subop_e;

  typedef enum logic [2:0] {
    SUB_JMP  = 3'b000,
    SUB_JR   = 3'b001,
    SUB_BZ   = 3'b010,
    SUB_BNZ  = 3'b011,
    SUB_CALL = 3'b100,
    SUB_HALT = 3'b111
  } ctrl_subop_e;

  typedef enum logic [1:0] {
    PC_SEL_INC  = 2'd0,
    PC_SEL_IMM1 = 2'd1,
    PC_SEL_RB1  = 2'd2,
    PC_SEL_ZERO = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ADDR_SEL_PC   = 2'd0,
    ADDR_SEL_RB1  = 2'd1,
    ADDR_SEL_IMM2 = 2'd2,
    ADDR_SEL_ALU  = 2'd3
  } addr_sel_e;

  typedef enum logic [1:0] {
    DIN_SEL_ALU  = 2'd0,
    DIN_SEL_MEM  = 2'd1,
    DIN_SEL_IMM2 = 2'd2,
    DIN_SEL_PC   = 2'd3
  } din_sel_e;

  // Exactly one field is set for any opcode; unmapped subops land in nop.
  typedef struct packed {
    logic alu_rr;
    logic alu_ri;
    logic ld;
    logic st;
    logic ldi;
    logic lda;
    logic sta;
    logic jmp;
    logic jr;
    logic bz;
    logic bnz;
    logic call;
    logic halt;
    logic nop;
  } instr_kind_t;

  function automatic op_class_e opcode_class(input logic [4:0] op);
    return op_class_e'(op[4:3]);
  endfunction

  function automatic logic [2:0] opcode_subop(input logic [4:0] op);
    return op[2:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cu_opcode_decode.sv
// ============================================================================
// Module   : cu_opcode_decode
// Purpose  : Combinational opcode to one-hot instruction-kind decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_opcode_decode
  import cu_pkg::*;
(
  input  logic [4:0]  opcode,
  output instr_kind_t kind
);

  logic [2:0] subop;

  assign subop = opcode_subop(opcode);

  always_comb begin
    kind = '0;
    case (opcode_class(opcode))
      CLS_ALU_RR: kind.alu_rr = 1'b1;
      CLS_ALU_RI: kind.alu_ri = 1'b1;
      CLS_MEM: begin
        case (subop)
          SUB_LD:  kind.ld  = 1'b1;
          SUB_ST:  kind.st  = 1'b1;
          SUB_LDI: kind.ldi = 1'b1;
          SUB_LDA: kind.lda = 1'b1;
          SUB_STA: kind.sta = 1'b1;
          default: kind.nop = 1'b1;
        endcase
      end
      CLS_CTRL: begin
        case (subop)
          SUB_JMP:  kind.jmp  = 1'b1;
          SUB_JR:   kind.jr   = 1'b1;
          SUB_BZ:   kind.bz   = 1'b1;
          SUB_BNZ:  kind.bnz  = 1'b1;
          SUB_CALL: kind.call = 1'b1;
          SUB_HALT: kind.halt = 1'b1;
          default:  kind.nop  = 1'b1;
        endcase
      end
      default: kind.nop = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
// Module   : cpu_control_unit
// Purpose  : Multicycle control FSM sequencing the 16-bit CPU datapath.
//            Optional macro CU_MEM_WAIT_EN stalls memory states on mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_unit
  import cu_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int Z_BIT     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           opcode,
  input  logic [WORD_SIZE-1:0] status_reg,
  input  logic                 mem_ready,
  output logic                 ALU_in2_mux,
  output logic                 mem_out_mux,
  output logic [1:0]           PC_mux,
  output logic [1:0]           memory_addr_mux,
  output logic [1:0]           data_in_mux,
  output logic                 reg_buff1_write,
  output logic                 reg_buff2_write,
  output logic                 status_reg_write,
  output logic                 ALU_out_write,
  output logic                 reg_write,
  output logic                 PC_write,
  output logic                 IR_write,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 halted
);

  state_e      state_q;
  state_e      state_d;
  instr_kind_t kind;
  logic        mem_go;
  logic        zero_flag;
  logic        unused_inputs;

  cu_opcode_decode u_decode (
    .opcode (opcode),
    .kind   (kind)
  );

`ifdef CU_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  assign zero_flag     = status_reg[Z_BIT];
  assign unused_inputs = ^{status_reg, mem_ready};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ALU_in2_mux      = 1'b0;
    mem_out_mux      = 1'b0;
    PC_mux           = PC_SEL_INC;
    memory_addr_mux  = ADDR_SEL_PC;
    data_in_mux      = DIN_SEL_ALU;
    reg_buff1_write  = 1'b0;
    reg_buff2_write  = 1'b0;
    status_reg_write = 1'b0;
    ALU_out_write    = 1'b0;
    reg_write        = 1'b0;
    PC_write         = 1'b0;
    IR_write         = 1'b0;
    mem_req          = 1'b0;
    mem_write        = 1'b0;
    halted           = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      // Strobes and selects stay up while stalled; only the enables wait.
      ST_FETCH: begin
        mem_req         = 1'b1;
        memory_addr_mux = ADDR_SEL_PC;
        PC_mux          = PC_SEL_INC;
        IR_write        = mem_go;
        PC_write        = mem_go;
        if (mem_go) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        reg_buff1_write = 1'b1;
        reg_buff2_write = 1'b1;
        if (kind.alu_rr || kind.alu_ri)                 state_d = ST_EXEC;
        else if (kind.ld || kind.lda)                   state_d = ST_MEM_RD;
        else if (kind.st || kind.sta)                   state_d = ST_MEM_WR;
        else if (kind.ldi)                              state_d = ST_WB_IMM;
        else if (kind.jmp || kind.jr || kind.bz || kind.bnz) state_d = ST_BRANCH;
        else if (kind.call)                             state_d = ST_CALL;
        else if (kind.halt)                             state_d = ST_HALT;
        else                                            state_d = ST_FETCH;
      end

      ST_EXEC: begin
        ALU_out_write    = 1'b1;
        status_reg_write = 1'b1;
        ALU_in2_mux      = kind.alu_rr;
        state_d          = ST_WB_ALU;
      end

      ST_WB_ALU: begin
        reg_write   = 1'b1;
        data_in_mux = DIN_SEL_ALU;
        state_d     = ST_FETCH;
      end

      ST_MEM_RD: begin
        mem_req         = 1'b1;
        memory_addr_mux = kind.lda ? ADDR_SEL_IMM2 : ADDR_SEL_RB1;
        data_in_mux     = DIN_SEL_MEM;
        reg_write       = mem_go;
        if (mem_go) state_d = ST_FETCH;
      end

      ST_MEM_WR: begin
        mem_req         = 1'b1;
        mem_write       = 1'b1;
        memory_addr_mux = kind.sta ? ADDR_SEL_IMM2 : ADDR_SEL_RB1;
        mem_out_mux     = kind.sta;
        if (mem_go) state_d = ST_FETCH;
      end

      ST_WB_IMM: begin
        reg_write   = 1'b1;
        data_in_mux = DIN_SEL_IMM2;
        state_d     = ST_FETCH;
      end

      // Flags come from the last completed ALU op; BZ/BNZ only commit on match.
      ST_BRANCH: begin
        PC_mux   = kind.jr ? PC_SEL_RB1 : PC_SEL_IMM1;
        PC_write = kind.jmp | kind.jr | (kind.bz & zero_flag) | (kind.bnz & ~zero_flag);
        state_d  = ST_FETCH;
      end

      // PC already points past CALL, so it is the return address written here.
      ST_CALL: begin
        reg_write   = 1'b1;
        data_in_mux = DIN_SEL_PC;
        PC_write    = 1'b1;
        PC_mux      = PC_SEL_IMM1;
        state_d     = ST_FETCH;
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: state_d = ST_BOOT;
    endcase
  end

endmodule

`default_nettype wire
